// File: rtl/tl_ul_master.sv
// -----------------------------------------------------------------------------
// tl_ul_master
//
// Single-outstanding TL-UL master. It turns one host register command at a
// time into a channel-A request, waits for the matching channel-D response
// and hands a one-cycle response pulse back to the host. It also selects the
// channel-A opcode, checks the response opcode and enforces a response timeout.
//
// Parameters:
//   TIMEOUT  WAIT-state cycles allowed before a timeout error (1..2^CNT_W-1)
//   CNT_W    width of the saturating timeout counter
//
// Ports:
//   clk, rst_n                 clock; asynchronous active-low reset
//   cmd_valid / cmd_ready      host command handshake
//   cmd_write                  1 = write, 0 = read
//   cmd_addr, cmd_mask         register address and byte enables
//   cmd_wdata                  write data
//   rsp_valid                  one-cycle response pulse (no back-pressure)
//   rsp_data, rsp_err          read data / error flag, qualified by rsp_valid
//   a_valid / a_ready          channel-A handshake
//   a_opcode, a_mask,
//   a_address, a_data          channel-A request fields (0 outside REQ)
//   d_ready                    always 1 once out of reset
//   d_valid                    single-cycle channel-D response pulse
//   d_opcode, d_data           channel-D response opcode and data
// -----------------------------------------------------------------------------
module tl_ul_master #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  // host command side
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [3:0]  cmd_addr,
  input  logic [3:0]  cmd_mask,
  input  logic [31:0] cmd_wdata,
  // host response side
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  // TL-UL channel A
  output logic        a_valid,
  input  logic        a_ready,
  output logic [3:0]  a_opcode,
  output logic [3:0]  a_mask,
  output logic [3:0]  a_address,
  output logic [31:0] a_data,
  // TL-UL channel D
  output logic        d_ready,
  input  logic        d_valid,
  input  logic [3:0]  d_opcode,
  input  logic [31:0] d_data
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  // Channel-A opcodes
  localparam logic [3:0] OP_PUT_FULL    = 4'd0;
  localparam logic [3:0] OP_PUT_PARTIAL = 4'd1;
  localparam logic [3:0] OP_GET         = 4'd4;
  // Channel-D opcodes
  localparam logic [3:0] OP_ACK         = 4'd0;
  localparam logic [3:0] OP_ACK_DATA    = 4'd1;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  cnt_inc;
  logic              write_q, write_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              a_valid_q, a_valid_d;
  logic [3:0]        a_opcode_q, a_opcode_d;
  logic [3:0]        a_mask_q, a_mask_d;
  logic [3:0]        a_address_q, a_address_d;
  logic [31:0]       a_data_q, a_data_d;
  logic              d_ready_q, d_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;
  logic [3:0]        exp_d_opcode;

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    write_d     = write_q;
    a_opcode_d  = a_opcode_q;
    a_mask_d    = a_mask_q;
    a_address_d = a_address_q;
    a_data_d    = a_data_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = '0;
    rsp_err_d   = 1'b0;

    // Saturating increment: the counter can never wrap back below TIMEOUT.
    cnt_inc      = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    exp_d_opcode = write_q ? OP_ACK : OP_ACK_DATA;

    case (state_q)
      ST_IDLE: begin
        // cmd_ready_q is low in the first cycle out of reset, so a command
        // presented then is not taken.
        if (cmd_valid && cmd_ready_q) begin
          state_d     = ST_REQ;
          write_d     = cmd_write;
          a_mask_d    = cmd_mask;
          a_address_d = cmd_addr;
          if (!cmd_write) begin
            a_opcode_d = OP_GET;
            a_data_d   = '0;
          end else begin
            a_opcode_d = (cmd_mask == 4'hF) ? OP_PUT_FULL : OP_PUT_PARTIAL;
            a_data_d   = cmd_wdata;
          end
        end
      end

      ST_REQ: begin
        // No timeout here: a stalled slave holds the request indefinitely.
        if (a_ready) begin
          state_d     = ST_WAIT;
          cnt_d       = '0;
          a_opcode_d  = '0;
          a_mask_d    = '0;
          a_address_d = '0;
          a_data_d    = '0;
        end
      end

      ST_WAIT: begin
        cnt_d = cnt_inc;
        // A response arriving in the timeout cycle takes priority.
        if (d_valid) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          if (d_opcode == exp_d_opcode) begin
            rsp_data_d = write_q ? '0 : d_data;
          end else begin
            rsp_err_d  = 1'b1;
          end
        end else if (cnt_inc == TIMEOUT_C) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Handshake outputs are registered copies of the state being entered.
    cmd_ready_d = (state_d == ST_IDLE);
    a_valid_d   = (state_d == ST_REQ);
    d_ready_d   = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // its pre-edge inputs regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      write_q     <= 1'b0;
      cmd_ready_q <= 1'b0;
      a_valid_q   <= 1'b0;
      a_opcode_q  <= '0;
      a_mask_q    <= '0;
      a_address_q <= '0;
      a_data_q    <= '0;
      d_ready_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      cmd_ready_q <= cmd_ready_d;
      a_valid_q   <= a_valid_d;
      a_opcode_q  <= a_opcode_d;
      a_mask_q    <= a_mask_d;
      a_address_q <= a_address_d;
      a_data_q    <= a_data_d;
      d_ready_q   <= d_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign a_valid   = a_valid_q;
  assign a_opcode  = a_opcode_q;
  assign a_mask    = a_mask_q;
  assign a_address = a_address_q;
  assign a_data    = a_data_q;
  assign d_ready   = d_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_tl_ul_master.sv
// -----------------------------------------------------------------------------
// tb_tl_ul_master
//
// Directed bench for tl_ul_master. Each transaction pushes its expected host
// response to a scoreboard queue when the command is driven; a monitor pops
// and compares whenever the DUT raises rsp_valid. The directed sequence also
// checks cycle timing, channel-A fields, stalls, timeouts and reset abort.
// -----------------------------------------------------------------------------
module tb_tl_ul_master;

  localparam int TIMEOUT = 15;
  localparam int CNT_W   = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [3:0]  cmd_addr;
  logic [3:0]  cmd_mask;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        a_valid;
  logic        a_ready;
  logic [3:0]  a_opcode;
  logic [3:0]  a_mask;
  logic [3:0]  a_address;
  logic [31:0] a_data;
  logic        d_ready;
  logic        d_valid;
  logic [3:0]  d_opcode;
  logic [31:0] d_data;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } rsp_t;

  rsp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  tl_ul_master #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_mask  (cmd_mask),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .a_opcode  (a_opcode),
    .a_mask    (a_mask),
    .a_address (a_address),
    .a_data    (a_data),
    .d_ready   (d_ready),
    .d_valid   (d_valid),
    .d_opcode  (d_opcode),
    .d_data    (d_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready, 0);
    check({tag, "_a_valid"},   a_valid,   0);
    check({tag, "_a_opcode"},  a_opcode,  0);
    check({tag, "_a_mask"},    a_mask,    0);
    check({tag, "_a_address"}, a_address, 0);
    check({tag, "_a_data"},    a_data,    0);
    check({tag, "_d_ready"},   d_ready,   0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_data"},  rsp_data,  0);
    check({tag, "_rsp_err"},   rsp_err,   0);
  endtask

  // Scoreboard monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    rsp_t e;
    if (rst_n === 1'b1 && rsp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL spurious_rsp: observed rsp_valid=1, expected no response pending");
      end else begin
        e = sb.pop_front();
        check("rsp_err",  rsp_err,  e.err);
        check("rsp_data", rsp_data, e.data);
      end
    end
  end

  // One host transaction against a directed slave.
  //   stall   : cycles a_ready is held low in REQ
  //   d_wait  : WAIT cycle (1-based) in which d_valid pulses; 0 = never
  //   hold    : keep cmd_valid high throughout
  //   abort_k : WAIT cycle in which rst_n is pulsed low; 0 = no abort
  task automatic run_txn(input logic wr, input logic [3:0] addr, input logic [3:0] mask,
                         input logic [31:0] wdata, input int stall, input int d_wait,
                         input logic [3:0] d_op, input logic [31:0] dd,
                         input bit hold, input int abort_k);
    logic [3:0]  exp_a_op;
    logic [31:0] exp_a_data;
    logic [3:0]  exp_d_op;
    rsp_t        exp;
    int          r;
    int          n;

    exp_a_op   = !wr ? 4'd4 : ((mask == 4'hF) ? 4'd0 : 4'd1);
    exp_a_data = wr ? wdata : 32'h0;
    exp_d_op   = wr ? 4'd0 : 4'd1;
    if (d_wait == 0 || d_op != exp_d_op) begin
      exp.err  = 1'b1;
      exp.data = 32'h0;
    end else begin
      exp.err  = 1'b0;
      exp.data = wr ? 32'h0 : dd;
    end
    r = (d_wait != 0) ? d_wait + 1 : TIMEOUT + 1;

    // Cycle 0: present the command while cmd_ready is high.
    n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_mask  = mask;
    cmd_wdata = wdata;
    a_ready   = (stall == 0);
    if (abort_k == 0) sb.push_back(exp);

    // Cycle 1: request on channel A.
    tick();
    if (!hold) cmd_valid = 1'b0;
    check("req_cmd_ready", cmd_ready, 0);
    check("req_a_valid",   a_valid,   1);
    check("req_a_opcode",  a_opcode,  exp_a_op);
    check("req_a_mask",    a_mask,    mask);
    check("req_a_address", a_address, addr);
    check("req_a_data",    a_data,    exp_a_data);

    for (int s = 0; s < stall; s++) begin
      tick();
      check("stall_a_valid",   a_valid,   1);
      check("stall_a_opcode",  a_opcode,  exp_a_op);
      check("stall_a_mask",    a_mask,    mask);
      check("stall_a_address", a_address, addr);
      check("stall_a_data",    a_data,    exp_a_data);
      check("stall_rsp_valid", rsp_valid, 0);
    end
    a_ready = 1'b1;

    for (int k = 1; k <= r; k++) begin
      tick();
      d_valid = 1'b0;
      if (k == abort_k) begin
        rst_n = 1'b0;
        #1;
        check_reset_values("abort");
        tick();
        tick();
        check_reset_values("abort_hold");
        rst_n = 1'b1;
        tick();
        check("abort_cmd_ready", cmd_ready, 1);
        check("abort_d_ready",   d_ready,   1);
        return;
      end
      if (k < r) begin
        check("wait_rsp_valid", rsp_valid, 0);
        check("wait_a_valid",   a_valid,   0);
        check("wait_a_data",    a_data,    0);
        if (k == d_wait) begin
          d_valid  = 1'b1;
          d_opcode = d_op;
          d_data   = dd;
        end
      end else begin
        check("rsp_valid_pulse", rsp_valid, 1);
      end
    end

    tick();
    check("rsp_valid_once", rsp_valid, 0);
    check("cmd_ready_back", cmd_ready, 1);
  endtask

  // Watchdog: the directed sequence is far shorter than this.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = 4'h0;
    cmd_mask  = 4'h0;
    cmd_wdata = 32'h0;
    a_ready   = 1'b1;
    d_valid   = 1'b0;
    d_opcode  = 4'h0;
    d_data    = 32'h0;

    // Reset values, then cmd_ready/d_ready rise on the first edge after release.
    tick();
    tick();
    check_reset_values("reset");
    rst_n = 1'b1;
    #1;
    check("release_cmd_ready", cmd_ready, 0);
    tick();
    check("first_cmd_ready", cmd_ready, 1);
    check("first_d_ready",   d_ready,   1);

    // Full write, ideal slave: d_valid in cycle 2, rsp in cycle 3.
    run_txn(1'b1, 4'h2, 4'hF, 32'h1234_5678, 0, 1, 4'd0, 32'h0, 1'b0, 0);
    // Partial write.
    run_txn(1'b1, 4'h7, 4'h3, 32'hA5A5_0F0F, 0, 1, 4'd0, 32'h0, 1'b0, 0);
    // Read: d_valid in cycle 4, rsp in cycle 5.
    run_txn(1'b0, 4'h5, 4'hF, 32'hFFFF_FFFF, 0, 3, 4'd1, 32'hCAFE_0001, 1'b0, 0);
    // a_ready low for 20 cycles in REQ.
    run_txn(1'b1, 4'h9, 4'h8, 32'hDEAD_BEEF, 20, 1, 4'd0, 32'h0, 1'b0, 0);
    // Read timeout.
    run_txn(1'b0, 4'hA, 4'h1, 32'h0, 0, 0, 4'd0, 32'h0, 1'b0, 0);
    // Write answered with AccessAckData: error, data forced to 0.
    run_txn(1'b1, 4'h3, 4'hF, 32'h0000_1111, 0, 1, 4'd1, 32'h5555_AAAA, 1'b0, 0);
    // Read answered with AccessAck: error.
    run_txn(1'b0, 4'h4, 4'hF, 32'h0, 0, 2, 4'd0, 32'h7777_8888, 1'b0, 0);
    // Response arriving in the timeout cycle is a normal response.
    run_txn(1'b0, 4'hB, 4'hF, 32'h0, 0, TIMEOUT, 4'd1, 32'h0BAD_F00D, 1'b0, 0);

    // Stray d_valid in IDLE is ignored.
    d_valid  = 1'b1;
    d_opcode = 4'd1;
    d_data   = 32'h1357_9BDF;
    tick();
    d_valid = 1'b0;
    check("stray_a_valid",   a_valid,   0);
    check("stray_cmd_ready", cmd_ready, 1);
    tick();
    check("stray_rsp_valid", rsp_valid, 0);

    // Back-to-back with cmd_valid held: one acceptance per transaction.
    run_txn(1'b0, 4'h6, 4'hC, 32'h0, 0, 3, 4'd1, 32'h2468_ACE0, 1'b1, 0);
    run_txn(1'b1, 4'hE, 4'hF, 32'hFEED_0001, 0, 1, 4'd0, 32'h0, 1'b0, 0);

    // Reset pulse in WAIT of a read drops the transaction.
    run_txn(1'b0, 4'h1, 4'hF, 32'h0, 0, 0, 4'd0, 32'h0, 1'b0, 3);
    repeat (20) tick();
    // Next command completes normally.
    run_txn(1'b1, 4'hC, 4'h6, 32'h0F0F_F0F0, 0, 1, 4'd0, 32'h0, 1'b0, 0);
    run_txn(1'b0, 4'hD, 4'hF, 32'h0, 0, 3, 4'd1, 32'h1111_2222, 1'b0, 0);

    tick();
    check("scoreboard_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
